// File: rtl/it8951_pixel_streamer_pkg.sv
// it8951_pixel_streamer_pkg: FSM state encodings, strobe phases and IT8951 i80 bus timing defaults.
//   Shared by it8951_pixel_streamer and it8951_i80_strobe; no ports.
package it8951_pixel_streamer_pkg;
   localparam int DEF_DSIZE       = 16;
   localparam int DEF_CNT_W       = 20;
   localparam int DEF_T_SETUP     = 1;
   localparam int DEF_T_STROBE    = 2;
   localparam int DEF_T_HOLD      = 1;
   localparam int DEF_RDY_TIMEOUT = 4096;
   // Settling time after FIFO_LOAD before FIFO_EMPTY reflects the reloaded FIFO.
   localparam int PRIME_CYCLES    = 4;
   typedef enum logic [2:0] {
      S_IDLE, S_PRIME, S_FETCH, S_LATCH, S_WAITRDY, S_SETUP, S_STROBE, S_HOLD
   } state_t;
   typedef enum logic [1:0] {
      PH_IDLE, PH_SETUP, PH_STROBE, PH_HOLD
   } phase_t;
   // Width of a counter that must hold values 0..n-1 (at least 1 bit).
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/it8951_i80_strobe.sv
// it8951_i80_strobe: generates one i80 write strobe (setup, HWE_N low, hold) per go pulse.
//   clk        in   clock
//   reset_n    in   synchronous active-low reset
//   go         in   1-cycle pulse: start a strobe sequence (only acted on while idle)
//   clear      in   abandon any sequence in progress, HWE_N back high next edge
//   hwe_n      out  registered write strobe, low for T_STROBE cycles
//   setup_end  out  last cycle of the setup phase
//   strobe_end out  last cycle of the low phase
//   done       out  last cycle of the hold phase
module it8951_i80_strobe
   import it8951_pixel_streamer_pkg::*;
#(
   parameter int T_SETUP  = DEF_T_SETUP,
   parameter int T_STROBE = DEF_T_STROBE,
   parameter int T_HOLD   = DEF_T_HOLD
) (
   input  logic clk,
   input  logic reset_n,
   input  logic go,
   input  logic clear,
   output logic hwe_n,
   output logic setup_end,
   output logic strobe_end,
   output logic done
);
   localparam int TMAX = (T_SETUP > T_STROBE) ? ((T_SETUP > T_HOLD) ? T_SETUP : T_HOLD)
                                              : ((T_STROBE > T_HOLD) ? T_STROBE : T_HOLD);
   localparam int CW = cnt_width(TMAX);
   phase_t phase, phase_nxt;
   logic [CW-1:0] cnt;
   always_comb begin
      setup_end  = (phase == PH_SETUP)  && (cnt == CW'(T_SETUP - 1));
      strobe_end = (phase == PH_STROBE) && (cnt == CW'(T_STROBE - 1));
      done       = (phase == PH_HOLD)   && (cnt == CW'(T_HOLD - 1));
      phase_nxt  = (phase == PH_IDLE) ? (go ? PH_SETUP : PH_IDLE)
                 : setup_end  ? PH_STROBE
                 : strobe_end ? PH_HOLD
                 : done       ? PH_IDLE
                 :              phase;
   end
   // hwe_n is registered from the next phase so the pin never glitches on phase decode.
   always_ff @(posedge clk) begin
      if (!reset_n || clear) begin
         phase <= PH_IDLE;
         cnt   <= '0;
         hwe_n <= 1'b1;
      end else begin
         phase <= phase_nxt;
         cnt   <= (phase_nxt != phase || phase == PH_IDLE) ? '0 : cnt + 1'b1;
         hwe_n <= (phase_nxt != PH_STROBE);
      end
   end
endmodule

// File: rtl/it8951_pixel_streamer.sv
// it8951_pixel_streamer: drains 16-bit pixel words from the SDRAM read FIFO and writes them
//   to the IT8951 i80 host bus as image-load data, one HRDY-paced strobe per word.
//   CLK, RESET_N           clock, synchronous active-low reset
//   START, ABORT           frame start (WORD_COUNT sampled) / terminate transfer
//   WORD_COUNT             words in the frame
//   BUSY, DONE, ERR        transfer status; DONE/ERR are 1-cycle pulses
//   FIFO_LOAD, FIFO_RD     FIFO reload pulse / read request
//   FIFO_DATA, FIFO_EMPTY  FIFO q (valid the cycle after FIFO_RD) / empty flag
//   HRDY                   IT8951 ready, asynchronous
//   HCS_N, HWE_N, HDC      i80 chip select, write strobe, data/command select
//   HD_OUT, HD_OE          host data bus and its tristate enable
module it8951_pixel_streamer
   import it8951_pixel_streamer_pkg::*;
#(
   parameter int DSIZE       = DEF_DSIZE,
   parameter int CNT_W       = DEF_CNT_W,
   parameter int T_SETUP     = DEF_T_SETUP,
   parameter int T_STROBE    = DEF_T_STROBE,
   parameter int T_HOLD      = DEF_T_HOLD,
   parameter int RDY_TIMEOUT = DEF_RDY_TIMEOUT
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             START,
   input  logic             ABORT,
   input  logic [CNT_W-1:0] WORD_COUNT,
   output logic             BUSY,
   output logic             DONE,
   output logic             ERR,
   output logic             FIFO_LOAD,
   output logic             FIFO_RD,
   input  logic [DSIZE-1:0] FIFO_DATA,
   input  logic             FIFO_EMPTY,
   input  logic             HRDY,
   output logic             HCS_N,
   output logic             HWE_N,
   output logic             HDC,
   output logic [DSIZE-1:0] HD_OUT,
   output logic             HD_OE
);
   localparam int TOW = cnt_width(RDY_TIMEOUT);
   localparam int PW  = cnt_width(PRIME_CYCLES);
   state_t state, state_nxt;
   logic rdy_m, rdy_s;
   logic [CNT_W-1:0] remaining;
   logic [TOW-1:0] tmo;
   logic [PW-1:0] prime_cnt;
   logic go, setup_end, strobe_end, strb_done;
   logic accept, zero_start, latch, timeout, word_end, finish, abort_act, stop;
   it8951_i80_strobe #(
      .T_SETUP  (T_SETUP),
      .T_STROBE (T_STROBE),
      .T_HOLD   (T_HOLD)
   ) u_strobe (
      .clk        (CLK),
      .reset_n    (RESET_N),
      .go         (go),
      .clear      (abort_act),
      .hwe_n      (HWE_N),
      .setup_end  (setup_end),
      .strobe_end (strobe_end),
      .done       (strb_done)
   );
   assign HDC  = 1'b1;
   assign stop = finish || timeout || abort_act;
   always_comb begin
      state_nxt  = state;
      FIFO_RD    = 1'b0;
      go         = 1'b0;
      accept     = 1'b0;
      zero_start = 1'b0;
      latch      = 1'b0;
      timeout    = 1'b0;
      word_end   = 1'b0;
      finish     = 1'b0;
      abort_act  = ABORT && (state != S_IDLE);
      case (state)
         S_IDLE: if (START) begin
            accept     = (WORD_COUNT != '0);
            zero_start = (WORD_COUNT == '0);
            state_nxt  = accept ? S_PRIME : S_IDLE;
         end
         S_PRIME:  state_nxt = (prime_cnt == PW'(PRIME_CYCLES - 1)) ? S_FETCH : S_PRIME;
         S_FETCH: begin
            FIFO_RD   = !FIFO_EMPTY;
            state_nxt = FIFO_EMPTY ? S_FETCH : S_LATCH;
         end
         S_LATCH: begin
            latch     = 1'b1;
            state_nxt = S_WAITRDY;
         end
         S_WAITRDY: begin
            go        = rdy_s;
            timeout   = !rdy_s && (tmo == TOW'(RDY_TIMEOUT - 1));
            state_nxt = rdy_s ? S_SETUP : timeout ? S_IDLE : S_WAITRDY;
         end
         S_SETUP:  state_nxt = setup_end ? S_STROBE : S_SETUP;
         S_STROBE: state_nxt = strobe_end ? S_HOLD : S_STROBE;
         S_HOLD: begin
            word_end  = strb_done;
            finish    = strb_done && (remaining == CNT_W'(1));
            state_nxt = !strb_done ? S_HOLD : finish ? S_IDLE : S_FETCH;
         end
         default:  state_nxt = S_IDLE;
      endcase
      // ABORT overrides every other event of the same cycle, including a pending DONE or ERR.
      if (abort_act) begin
         state_nxt = S_IDLE;
         FIFO_RD   = 1'b0;
         go        = 1'b0;
         latch     = 1'b0;
         timeout   = 1'b0;
         word_end  = 1'b0;
         finish    = 1'b0;
      end
   end
   always_ff @(posedge CLK) begin
      if (!RESET_N) state <= S_IDLE;
      else          state <= state_nxt;
   end
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         rdy_m     <= 1'b0;
         rdy_s     <= 1'b0;
         remaining <= '0;
         tmo       <= '0;
         prime_cnt <= '0;
         BUSY      <= 1'b0;
         DONE      <= 1'b0;
         ERR       <= 1'b0;
         FIFO_LOAD <= 1'b0;
         HCS_N     <= 1'b1;
         HD_OE     <= 1'b0;
         HD_OUT    <= '0;
      end else begin
         rdy_m     <= HRDY;
         rdy_s     <= rdy_m;
         prime_cnt <= (state == S_PRIME) ? prime_cnt + 1'b1 : '0;
         // Held at zero outside WAITRDY, so it starts from zero on every entry; saturates.
         tmo       <= (state == S_WAITRDY) ? tmo + TOW'(~&tmo) : '0;
         if (accept)        remaining <= WORD_COUNT;
         else if (word_end) remaining <= remaining - 1'b1;
         if (latch) begin
            HD_OUT <= FIFO_DATA;
            HCS_N  <= 1'b0;
            HD_OE  <= 1'b1;
         end
         if (stop) begin
            HCS_N <= 1'b1;
            HD_OE <= 1'b0;
         end
         BUSY      <= accept || (BUSY && !stop);
         DONE      <= finish || zero_start;
         ERR       <= timeout;
         FIFO_LOAD <= accept;
      end
   end
endmodule
